// File: rtl/sym_fir_filt_if.sv
// rtl/sym_fir_filt_if.sv - sample, coefficient and result signals of sym_fir_filt
//
// Purpose: groups the signals exchanged with the symmetric FIR filter.
// Signals:
//   sam_clk_en  one new sample accepted per high cycle
//   x_in        signed input sample (DW)
//   coeff_wr    coefficient write strobe
//   coeff_addr  unique-coefficient index (AW); 0 = outer taps
//   coeff_data  signed coefficient value (CW)
//   y           signed filtered sample (DW), held between valid pulses
//   y_valid     one-cycle pulse per output sample
//   sat_flag    qualified by y_valid; 1 = y was clipped
// Modports: master drives samples/coefficients, slave is the filter.
interface sym_fir_filt_if #(
  parameter int DW = 18,
  parameter int CW = 18,
  parameter int AW = 4
);
  logic                 sam_clk_en;
  logic signed [DW-1:0] x_in;
  logic                 coeff_wr;
  logic [AW-1:0]        coeff_addr;
  logic signed [CW-1:0] coeff_data;
  logic signed [DW-1:0] y;
  logic                 y_valid;
  logic                 sat_flag;

  modport master (
    output sam_clk_en, x_in, coeff_wr, coeff_addr, coeff_data,
    input  y, y_valid, sat_flag
  );

  modport slave (
    input  sam_clk_en, x_in, coeff_wr, coeff_addr, coeff_data,
    output y, y_valid, sat_flag
  );
endinterface

// File: rtl/sym_fir_filt.sv
// rtl/sym_fir_filt.sv - parametrised symmetric linear-phase FIR filter
//
// Purpose: N_TAPS-tap symmetric FIR with run-time loadable coefficients,
// a delay line advanced by sam_clk_en, a 4-stage free-running pipeline
// (pre-add, multiply, sum, round/saturate) and a per-sample overflow flag.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; clears delay line, pipeline, coefficients
//   bus    sym_fir_filt_if.slave: sam_clk_en, x_in, coeff_wr, coeff_addr,
//          coeff_data in; y, y_valid, sat_flag out
module sym_fir_filt #(
  parameter int N_TAPS = 21,
  parameter int DW     = 18,
  parameter int CW     = 18,
  parameter int AW     = $clog2((N_TAPS + 1) / 2)
) (
  input  logic          clk,
  input  logic          reset,
  sym_fir_filt_if.slave bus
);

  localparam int NUNIQ = (N_TAPS + 1) / 2;
  localparam int PW    = DW + 1;            // pre-add width, cannot overflow
  localparam int MW    = PW + CW;           // full product width
  localparam int GW    = $clog2(NUNIQ);     // guard bits for the adder tree
  localparam int SW    = MW + GW;           // full-precision sum width

  // Rounding offset (half LSB of the output) and output clip limits,
  // expressed at sum width so the comparisons stay signed and exact.
  localparam logic signed [SW-1:0] HALF = SW'(1) << (CW - 2);
  localparam logic signed [SW-1:0] YMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] YMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0] xd   [N_TAPS];
  logic signed [CW-1:0] b    [NUNIQ];
  logic signed [PW-1:0] p_r  [NUNIQ];
  logic signed [MW-1:0] m_r  [NUNIQ];
  logic signed [SW-1:0] sum_r;
  logic [3:0]           vld;  // valid token per pipeline stage

  logic signed [SW-1:0] sum_c;
  logic signed [SW-1:0] rnd_c;
  logic signed [SW-1:0] shf_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUNIQ; i++) begin
      sum_c = sum_c + SW'(m_r[i]);
    end
    rnd_c = sum_r + HALF;
    shf_c = rnd_c >>> (CW - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) xd[i] <= '0;
      for (int i = 0; i < NUNIQ; i++) begin
        b[i]   <= '0;
        p_r[i] <= '0;
        m_r[i] <= '0;
      end
      sum_r        <= '0;
      vld          <= '0;
      bus.y        <= '0;
      bus.y_valid  <= 1'b0;
      bus.sat_flag <= 1'b0;
    end else begin
      // Delay line only moves on a sample enable.
      if (bus.sam_clk_en) begin
        xd[0] <= bus.x_in;
        for (int i = 1; i < N_TAPS; i++) xd[i] <= xd[i-1];
      end

      // Address compare per entry: out-of-range addresses match nothing.
      for (int i = 0; i < NUNIQ; i++) begin
        if (bus.coeff_wr && bus.coeff_addr == AW'(i)) b[i] <= bus.coeff_data;
      end

      // Stage 1: fold the symmetric taps; the centre tap is unpaired.
      for (int i = 0; i < NUNIQ - 1; i++) begin
        p_r[i] <= {xd[i][DW-1], xd[i]} + {xd[N_TAPS-1-i][DW-1], xd[N_TAPS-1-i]};
      end
      p_r[NUNIQ-1] <= {xd[NUNIQ-1][DW-1], xd[NUNIQ-1]};

      // Stage 2: full-width products against the live coefficients.
      for (int i = 0; i < NUNIQ; i++) begin
        m_r[i] <= MW'(p_r[i]) * MW'(b[i]);
      end

      // Stage 3: full-precision sum.
      sum_r <= sum_c;

      // Stage 4: round half up, saturate; y/sat_flag hold without a token.
      vld         <= {vld[2:0], bus.sam_clk_en};
      bus.y_valid <= vld[3];
      if (vld[3]) begin
        if (shf_c > YMAX) begin
          bus.y        <= {1'b0, {(DW-1){1'b1}}};
          bus.sat_flag <= 1'b1;
        end else if (shf_c < YMIN) begin
          bus.y        <= {1'b1, {(DW-1){1'b0}}};
          bus.sat_flag <= 1'b1;
        end else begin
          bus.y        <= shf_c[DW-1:0];
          bus.sat_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sym_fir_filt.sv
// tb/tb_sym_fir_filt.sv - scoreboard testbench for sym_fir_filt
module tb_sym_fir_filt;

  localparam int N_TAPS = 21;
  localparam int DW     = 18;
  localparam int CW     = 18;
  localparam int NUNIQ  = (N_TAPS + 1) / 2;
  localparam int AW     = $clog2(NUNIQ);

  typedef struct {
    logic signed [DW-1:0] y;
    logic                 sat;
    int                   cap;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   rst_q;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t   q[$];
  longint got_y[$];
  longint got_s[$];
  longint last_y = 0;
  longint last_s = 0;

  longint mb [NUNIQ];
  longint mx [N_TAPS];

  sym_fir_filt_if #(.DW(DW), .CW(CW), .AW(AW)) bus ();

  sym_fir_filt #(.N_TAPS(N_TAPS), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each valid, otherwise checks hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      check("rst_y", bus.y, 0);
      check("rst_valid", {63'd0, bus.y_valid}, 0);
      check("rst_sat", {63'd0, bus.sat_flag}, 0);
      q.delete();
      last_y = 0;
      last_s = 0;
    end else if (bus.y_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_valid", {63'd0, bus.y_valid}, 0);
      end else begin
        e = q.pop_front();
        check("y", bus.y, e.y);
        check("sat", {63'd0, bus.sat_flag}, {63'd0, e.sat});
        check("latency", cyc - e.cap, 4);
      end
      last_y = bus.y;
      last_s = bus.sat_flag;
      got_y.push_back(bus.y);
      got_s.push_back(bus.sat_flag);
    end else begin
      check("hold_y", bus.y, last_y);
      check("hold_sat", {63'd0, bus.sat_flag}, last_s);
    end
  end

  task automatic sample(input bit en, input longint x);
    longint sum, r, h;
    exp_t e;
    @(posedge clk); #1;
    bus.coeff_wr   = 1'b0;
    bus.sam_clk_en = en;
    bus.x_in       = DW'(x);
    if (en) begin
      for (int i = N_TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
      mx[0] = x;
      sum = 0;
      for (int i = 0; i < N_TAPS; i++) begin
        h = (i < NUNIQ) ? mb[i] : mb[N_TAPS-1-i];
        sum += mx[i] * h;
      end
      r = (sum + (64'sd1 << (CW - 2))) >>> (CW - 1);
      e.sat = 1'b0;
      if (r > 131071) begin r = 131071; e.sat = 1'b1; end
      if (r < -131072) begin r = -131072; e.sat = 1'b1; end
      e.y   = DW'(r);
      e.cap = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic write_coeff(input int addr, input longint data);
    @(posedge clk); #1;
    bus.sam_clk_en = 1'b0;
    bus.coeff_wr   = 1'b1;
    bus.coeff_addr = AW'(addr);
    bus.coeff_data = CW'(data);
    if (addr < NUNIQ) mb[addr] = data;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    bus.sam_clk_en = 1'b0;
    bus.coeff_wr   = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    check("drain", q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset(input int n, input bit en, input longint x);
    @(posedge clk); #1;
    reset          = 1'b1;
    bus.sam_clk_en = en;
    bus.coeff_wr   = 1'b0;
    bus.x_in       = DW'(x);
    for (int i = 0; i < NUNIQ; i++) mb[i] = 0;
    for (int i = 0; i < N_TAPS; i++) mx[i] = 0;
    repeat (n - 1) @(posedge clk);
    @(posedge clk); #1;
    reset          = 1'b0;
    bus.sam_clk_en = 1'b0;
  endtask

  task automatic load_impulse_coeffs();
    for (int i = 0; i < NUNIQ; i++) write_coeff(i, 1000 * (i + 1));
  endtask

  // Flush history with zeros, then an impulse of 65536; spacing = cycles per sample.
  task automatic impulse(input int spacing, input longint tap3);
    longint e;
    for (int i = 0; i < N_TAPS; i++) sample(1'b1, 0);
    drain();
    got_y.delete();
    got_s.delete();
    for (int k = 0; k < 26; k++) begin
      sample(1'b1, (k == 0) ? 65536 : 0);
      for (int j = 1; j < spacing; j++) sample(1'b0, 0);
    end
    drain();
    check("imp_len", got_y.size(), 26);
    if (got_y.size() >= 22) begin
      for (int j = 0; j < 22; j++) begin
        if (j <= 10) e = 500 * (j + 1);
        else if (j <= 20) e = 500 * (21 - j);
        else e = 0;
        if (j == 3 || j == 17) e = tap3;
        check($sformatf("imp_y%0d", j), got_y[j], e);
        check($sformatf("imp_sat%0d", j), got_s[j], 0);
      end
    end
  endtask

  task automatic hold_input(input longint x, input longint ey, input longint es);
    got_y.delete();
    got_s.delete();
    for (int i = 0; i < 25; i++) sample(1'b1, x);
    drain();
    if (got_y.size() > 0) begin
      check($sformatf("steady_y_%0d", x), got_y[$], ey);
      check($sformatf("steady_sat_%0d", x), got_s[$], es);
    end else begin
      check("steady_count", got_y.size(), 25);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: cycle %0d, pending %0d", cyc, q.size());
    $fatal(1, "timeout");
  end

  initial begin
    bus.sam_clk_en = 1'b0;
    bus.x_in       = '0;
    bus.coeff_wr   = 1'b0;
    bus.coeff_addr = '0;
    bus.coeff_data = '0;
    do_reset(2, 1'b0, 0);

    // Impulse with default-style coefficients, every cycle then 1 in 4.
    load_impulse_coeffs();
    impulse(1, 2000);
    impulse(4, 2000);

    // Out-of-range coefficient writes must not disturb the response.
    for (int a = NUNIQ; a < 16; a++) write_coeff(a, 7777);
    impulse(1, 2000);

    // Rewritten coefficient shows up on both symmetric taps.
    write_coeff(3, -2000);
    impulse(1, -1000);

    // Saturation, both polarities.
    for (int i = 0; i < NUNIQ; i++) write_coeff(i, 131071);
    hold_input(131071, 131071, 1);
    hold_input(-131072, -131072, 1);

    // Rounding half up on the centre tap only.
    for (int i = 0; i < NUNIQ; i++) write_coeff(i, (i == NUNIQ - 1) ? 65536 : 0);
    hold_input(101, 51, 0);
    hold_input(-101, -50, 0);

    // Reset two cycles after an impulse capture drops it and clears coefficients.
    load_impulse_coeffs();
    for (int i = 0; i < N_TAPS; i++) sample(1'b1, 0);
    drain();
    sample(1'b1, 65536);
    sample(1'b0, 0);
    do_reset(1, 1'b1, 999);
    hold_input(5000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
